// File: rtl/div_reconstruct.sv
// div_reconstruct: sequential shift-add check that quotient*divisor+remainder rebuilds the dividend (ports: clk, rst, start, quotient, divisor, remainder, dividend_exp in; busy, done, dividend, div_zero, consistent, match out)
module div_reconstruct #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   quotient,
  input  logic [WIDTH-1:0]   divisor,
  input  logic [WIDTH-1:0]   remainder,
  input  logic [WIDTH-1:0]   dividend_exp,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] dividend,
  output logic               div_zero,
  output logic               consistent,
  output logic               match
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state, state_nx;
  logic [2*WIDTH-1:0] acc, mcand, acc_nx;
  logic [WIDTH-1:0] mplier, rem_q, div_q, exp_q;
  logic [CW-1:0] cnt;
  logic accept, last;
  always_comb begin
    accept = start && (state == IDLE || state == DONE);
    last = state == MUL && cnt == CW'(WIDTH - 1);
    acc_nx = mplier[0] ? acc + mcand : acc;
    state_nx = accept ? MUL : state == DONE ? IDLE : last ? DONE : state;
  end
  assign busy = state == MUL;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
      rem_q <= '0;
      div_q <= '0;
      exp_q <= '0;
      dividend <= '0;
      div_zero <= 1'b0;
      consistent <= 1'b0;
      match <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        acc <= {{WIDTH{1'b0}}, remainder};
        mcand <= {{WIDTH{1'b0}}, divisor};
        mplier <= quotient;
        cnt <= '0;
        rem_q <= remainder;
        div_q <= divisor;
        exp_q <= dividend_exp;
      end else if (state == MUL) begin
        acc <= acc_nx;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + 1'b1;
      end
      // results are captured from the final partial sum so they are valid alongside done
      if (last) begin
        dividend <= acc_nx;
        div_zero <= div_q == '0;
        consistent <= div_q != '0 && rem_q < div_q && acc_nx[2*WIDTH-1:WIDTH] == '0;
        match <= div_q != '0 && rem_q < div_q && acc_nx == {{WIDTH{1'b0}}, exp_q};
      end
    end
  end
endmodule

// File: tb/tb_div_reconstruct.sv
// tb_div_reconstruct: scoreboard bench for div_reconstruct
module tb_div_reconstruct;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] quotient = '0, divisor = '0, remainder = '0, dividend_exp = '0;
  logic busy, done, div_zero, consistent, match;
  logic [2*W-1:0] dividend;
  typedef struct packed {
    logic [2*W-1:0] dv;
    logic dz;
    logic cs;
    logic mt;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  div_reconstruct #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .quotient(quotient), .divisor(divisor),
    .remainder(remainder), .dividend_exp(dividend_exp), .busy(busy), .done(done),
    .dividend(dividend), .div_zero(div_zero), .consistent(consistent), .match(match)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  task automatic drive(input logic [W-1:0] q, d, r, x);
    start = 1'b1;
    quotient = q;
    divisor = d;
    remainder = r;
    dividend_exp = x;
  endtask
  task automatic push(input logic [2*W-1:0] dv, input logic dz, cs, mt);
    exp_t e;
    e.dv = dv;
    e.dz = dz;
    e.cs = cs;
    e.mt = mt;
    sb.push_back(e);
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk) #1;
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout: done not seen within %0d cycles", n);
    end
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        e = sb.pop_front();
        if ({dividend, div_zero, consistent, match} !== e) begin
          errors++;
          $display("FAIL result: got dividend=%0d dz=%0b cs=%0b mt=%0b expected dividend=%0d dz=%0b cs=%0b mt=%0b",
                   dividend, div_zero, consistent, match, e.dv, e.dz, e.cs, e.mt);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  logic [W-1:0] vq[6] = '{4'd15, 4'd0, 4'd3, 4'd2, 4'd5, 4'd5};
  logic [W-1:0] vd[6] = '{4'd15, 4'd0, 4'd4, 4'd3, 4'd3, 4'd3};
  logic [W-1:0] vr[6] = '{4'd14, 4'd0, 4'd1, 4'd3, 4'd1, 4'd0};
  logic [W-1:0] vx[6] = '{4'd4, 4'd4, 4'd13, 4'd9, 4'd15, 4'd14};
  logic [2*W-1:0] edv[6] = '{8'd239, 8'd0, 8'd13, 8'd9, 8'd16, 8'd15};
  logic [2:0] eflags[6] = '{3'b000, 3'b100, 3'b011, 3'b000, 3'b000, 3'b010};
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dividend", dividend, 0);
    chk("reset_flags", {div_zero, consistent, match}, 0);
    drive(2, 2, 0, 4);
    push(4, 0, 1, 1);
    @(posedge clk) #1 start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_busy_c%0d", i + 1), busy, 1);
      chk($sformatf("t1_nodone_c%0d", i + 1), done, 0);
      @(posedge clk) #1;
    end
    chk("t1_done_c5", done, 1);
    chk("t1_busy_c5", busy, 0);
    @(posedge clk) #1;
    chk("t1_done_pulse", done, 0);
    chk("t1_hold_dividend", dividend, 4);
    chk("t1_hold_match", match, 1);
    for (int i = 0; i < 6; i++) begin
      drive(vq[i], vd[i], vr[i], vx[i]);
      push(edv[i], eflags[i][2], eflags[i][1], eflags[i][0]);
      @(posedge clk) #1 start = 1'b0;
      wait_done(n);
      chk($sformatf("vec%0d_latency", i), n, 4);
      @(posedge clk) #1;
    end
    drive(1, 1, 0, 1);
    push(1, 0, 1, 1);
    @(posedge clk) #1 start = 1'b0;
    @(posedge clk) #1;
    drive(7, 7, 3, 9);
    chk("t4_busy", busy, 1);
    @(posedge clk) #1 start = 1'b0;
    wait_done(n);
    chk("t4_latency", n, 2);
    drive(2, 1, 0, 2);
    push(2, 0, 1, 1);
    @(posedge clk) #1 start = 1'b0;
    chk("t5_accept_in_done", busy, 1);
    wait_done(n);
    chk("t5_latency", n + 1, 5);
    @(posedge clk) #1;
    drive(3, 3, 1, 10);
    @(posedge clk) #1 start = 1'b0;
    @(posedge clk) #1 rst = 1'b1;
    @(posedge clk) #1 rst = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_dividend", dividend, 0);
    chk("t6_flags", {div_zero, consistent, match}, 0);
    repeat (8) @(posedge clk);
    #1 chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
